alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Front-end controller for the 4-bit mini ALU. Walks the user through operand/command entry with one
//  ENTER key and one CLEAR key on the 10-bit switch bank, latches the operands, drives the ALU, waits
//  the ALU settle time, then registers and holds the 20-bit result for the display encoder.
//  Sits between board I/O (sw, keys) and miniALU + displayEncoder in the next top level.
// PARAMETERS
//  DEBOUNCE_CYCLES  500_000  stable cycles a key must hold before it is accepted (10 ms @ 50 MHz)
//  ALU_LATENCY      1        cycles operands are held stable before alu_result is sampled (>=1)
//  RESULT_W         20       width of ALU result and of the held result
// PORTS
//  clk            in   1         system clock
//  rst_n          in   1         asynchronous active-low reset
//  sw             in   10        raw switches; sw[3:0]=operand nibble, sw[1]=operation, sw[0]=sign
//  key_enter_n    in   1         raw ENTER push button, active-low, asynchronous to clk
//  key_clear_n    in   1         raw CLEAR push button, active-low, asynchronous to clk
//  alu_op1        out  4         operand 1 to ALU (registered)
//  alu_op2        out  4         operand 2 to ALU (registered)
//  alu_operation  out  1         operation select to ALU (registered)
//  alu_sign       out  1         sign select to ALU (registered)
//  alu_result     in   RESULT_W  combinational ALU result
//  disp_value     out  RESULT_W  value for display encoder
//  result_valid   out  1         high while disp_value holds a completed result
//  state_led      out  3         one-hot entry phase {CMD,OP2,OP1}; 0 in EXEC/SHOW
// BEHAVIOUR
//  Reset (async assert, sync release): state=S_OP1; alu_op1/op2/operation/sign=0; result register=0;
//   result_valid=0; state_led=3'b001; debouncers cleared to "released".
//  Keys: 2-flop synchronizer -> counter debounce (DEBOUNCE_CYCLES) -> one-cycle press pulse on
//   released->pressed transition only; holding a key produces exactly one pulse.
//  FSM (press pulses enter_p, clear_p):
//   S_OP1  : disp_value={16'b0,sw[3:0]} live; enter_p -> alu_op1<=sw[3:0], go S_OP2
//   S_OP2  : disp_value={16'b0,sw[3:0]} live; enter_p -> alu_op2<=sw[3:0], go S_CMD
//   S_CMD  : disp_value={18'b0,sw[1:0]} live; enter_p -> alu_operation<=sw[1], alu_sign<=sw[0],
//            wait_cnt<=0, go S_EXEC
//   S_EXEC : wait_cnt++ each cycle; when wait_cnt==ALU_LATENCY-1 register alu_result, set
//            result_valid, go S_SHOW. enter_p ignored. disp_value = previous held result.
//   S_SHOW : disp_value=held result; enter_p -> result_valid<=0, go S_OP1 (ALU regs keep values).
//  Latency: S_CMD enter_p cycle N -> result registered at edge N+ALU_LATENCY, result_valid high N+ALU_LATENCY.
//  clear_p in any state: go S_OP1, result_valid<=0, ALU regs and held result <=0, wait_cnt<=0.
//  clear_p and enter_p same cycle: clear wins, enter dropped.
//  sw changes during S_EXEC/S_SHOW have no effect on ALU inputs or held result.
//  Illegal state encoding -> S_OP1 (default branch), same actions as clear.
//  rst_n asserted mid-EXEC: immediate return to reset values; no partial result is ever held.
// STRUCTURE
//  Package alu_ctrl_pkg: typedef enum logic [2:0] seq_state_t {S_OP1,S_OP2,S_CMD,S_EXEC,S_SHOW};
//   localparams OPND_W=4, SW_W=10, RESULT_W default.
//  Sub-module key_debouncer (param DEBOUNCE_CYCLES; clk, rst_n, key_n -> press_p), instanced twice.
//  Top of this block: FSM, operand/command registers, wait counter, result register, display mux.
// TESTING (sim with DEBOUNCE_CYCLES=4, stub ALU: result = operation ? op1*op2 : op1+op2)
//  1 reset: rst_n low mid-sim -> all ALU outputs 0, result_valid 0, state_led=001, disp_value=sw[3:0].
//  2 full flow: sw=3,ENTER; sw=5,ENTER; sw[1:0]=00,ENTER -> ALU_LATENCY cycles later disp_value=8,
//    result_valid=1; sw[1]=1 after that -> disp_value stays 8, alu_operation stays 0.
//  3 bounce: ENTER toggled every 2 cycles for 20 cycles then held -> exactly one state advance.
//  4 held key: ENTER held 100 cycles in S_OP1 -> single advance to S_OP2, no skip to S_CMD.
//  5 clear priority: ENTER and CLEAR pulses same cycle in S_CMD -> S_OP1, alu_op1=alu_op2=0.
//  6 latency: ALU_LATENCY=3, op1=7,op2=6,operation=1 -> result 42 valid exactly 3 cycles after
//    final ENTER pulse; ENTER during S_EXEC ignored; ENTER in S_SHOW -> S_OP1, result_valid=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the mini-ALU front-end sequencer.
package alu_ctrl_pkg;

    localparam int OPND_W           = 4;
    localparam int SW_W             = 10;
    localparam int DEFAULT_RESULT_W = 20;

    typedef enum logic [2:0] {
        S_OP1,
        S_OP2,
        S_CMD,
        S_EXEC,
        S_SHOW
    } seq_state_t;

    // One-hot entry-phase indicator {CMD,OP2,OP1}; dark while executing or showing.
    function automatic logic [2:0] phase_led(input seq_state_t s);
        case (s)
            S_OP1:   return 3'b001;
            S_OP2:   return 3'b010;
            S_CMD:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Push-button conditioner: synchronizes an active-low raw key, debounces it with a
// stability counter and emits a single-cycle pulse on each accepted press.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_p
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             pressed_q, pressed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             pressed_raw;

    // Raw key is active-low; sync flops idle high so reset means "released".
    assign pressed_raw = ~sync2_q;
    assign press_p     = press_q;

    // Count consecutive cycles the synchronized key disagrees with the accepted level.
    always_comb begin
        pressed_d = pressed_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        if (pressed_raw != pressed_q) begin
            if (cnt_q == CNT_LAST) begin
                pressed_d = pressed_raw;
                press_d   = pressed_raw;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchronizer, accepted level, counter and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
        end else begin
            sync1_q   <= key_n;
            sync2_q   <= sync1_q;
            pressed_q <= pressed_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Operand/command entry sequencer for the mini ALU: collects two operands and a
// command from the switch bank, drives the ALU, waits for it to settle and holds
// the result for the display encoder.
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int ALU_LATENCY     = 1,
    parameter int RESULT_W        = DEFAULT_RESULT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SW_W-1:0]     sw,
    input  logic                key_enter_n,
    input  logic                key_clear_n,
    output logic [OPND_W-1:0]   alu_op1,
    output logic [OPND_W-1:0]   alu_op2,
    output logic                alu_operation,
    output logic                alu_sign,
    input  logic [RESULT_W-1:0] alu_result,
    output logic [RESULT_W-1:0] disp_value,
    output logic                result_valid,
    output logic [2:0]          state_led
);

    localparam int WAIT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ALU_LATENCY - 1);

    logic enter_p, clear_p;

    seq_state_t          state_q, state_d;
    logic [OPND_W-1:0]   op1_q, op1_d;
    logic [OPND_W-1:0]   op2_q, op2_d;
    logic                oper_q, oper_d;
    logic                sign_q, sign_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic                valid_q, valid_d;
    logic [2:0]          led_q, led_d;

    // Upper switches are not part of the entry protocol.
    logic sw_unused;
    assign sw_unused = ^sw[SW_W-1:OPND_W];

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_deb (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n   (key_enter_n),
        .press_p (enter_p)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_deb (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n   (key_clear_n),
        .press_p (clear_p)
    );

    // Next-state and datapath updates; clear (and any illegal state) wins over enter.
    always_comb begin
        state_d    = state_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        oper_d     = oper_q;
        sign_d     = sign_q;
        wait_cnt_d = wait_cnt_q;
        result_d   = result_q;
        valid_d    = valid_q;
        if (clear_p) begin
            state_d    = S_OP1;
            op1_d      = '0;
            op2_d      = '0;
            oper_d     = 1'b0;
            sign_d     = 1'b0;
            wait_cnt_d = '0;
            result_d   = '0;
            valid_d    = 1'b0;
        end else begin
            case (state_q)
                S_OP1: if (enter_p) begin
                    op1_d   = sw[OPND_W-1:0];
                    state_d = S_OP2;
                end
                S_OP2: if (enter_p) begin
                    op2_d   = sw[OPND_W-1:0];
                    state_d = S_CMD;
                end
                S_CMD: if (enter_p) begin
                    oper_d     = sw[1];
                    sign_d     = sw[0];
                    wait_cnt_d = '0;
                    state_d    = S_EXEC;
                end
                S_EXEC: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        result_d = alu_result;
                        valid_d  = 1'b1;
                        state_d  = S_SHOW;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                S_SHOW: if (enter_p) begin
                    valid_d = 1'b0;
                    state_d = S_OP1;
                end
                default: begin
                    state_d    = S_OP1;
                    op1_d      = '0;
                    op2_d      = '0;
                    oper_d     = 1'b0;
                    sign_d     = 1'b0;
                    wait_cnt_d = '0;
                    result_d   = '0;
                    valid_d    = 1'b0;
                end
            endcase
        end
        led_d = phase_led(state_d);
    end

    // State, ALU drive, wait counter, held result and LED registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_OP1;
            op1_q      <= '0;
            op2_q      <= '0;
            oper_q     <= 1'b0;
            sign_q     <= 1'b0;
            wait_cnt_q <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            led_q      <= 3'b001;
        end else begin
            state_q    <= state_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            oper_q     <= oper_d;
            sign_q     <= sign_d;
            wait_cnt_q <= wait_cnt_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            led_q      <= led_d;
        end
    end

    // Display shows live switch entry during entry phases, the held result otherwise.
    always_comb begin
        case (state_q)
            S_OP1, S_OP2: disp_value = {{(RESULT_W-OPND_W){1'b0}}, sw[OPND_W-1:0]};
            S_CMD:        disp_value = {{(RESULT_W-2){1'b0}}, sw[1:0]};
            default:      disp_value = result_q;
        endcase
    end

    assign alu_op1       = op1_q;
    assign alu_op2       = op2_q;
    assign alu_operation = oper_q;
    assign alu_sign      = sign_q;
    assign result_valid  = valid_q;
    assign state_led     = led_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a stub ALU and a phase-level model.
module tb_alu_op_sequencer;

    localparam int DEB  = 4;
    localparam int LAT  = 3;
    localparam int RW   = 20;
    localparam int HOLD = 12;

    // Model phases: what the operator is being asked for next.
    localparam int P_OP1  = 0;
    localparam int P_OP2  = 1;
    localparam int P_CMD  = 2;
    localparam int P_SHOW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [9:0]    sw;
    logic          key_enter_n, key_clear_n;
    logic [3:0]    alu_op1, alu_op2;
    logic          alu_operation, alu_sign;
    logic [RW-1:0] alu_result, disp_value;
    logic          result_valid;
    logic [2:0]    state_led;

    int n_checks = 0;
    int n_pass   = 0;

    int         m_phase;
    logic [3:0] m_op1, m_op2;
    logic       m_oper, m_sign, m_valid;
    logic [RW-1:0] m_res;

    always #5 clk = ~clk;

    // Stub ALU: multiply when operation=1, add otherwise.
    assign alu_result = alu_operation ? (RW'(alu_op1) * RW'(alu_op2)) : (RW'(alu_op1) + RW'(alu_op2));

    alu_op_sequencer #(.DEBOUNCE_CYCLES(DEB), .ALU_LATENCY(LAT), .RESULT_W(RW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sw            (sw),
        .key_enter_n   (key_enter_n),
        .key_clear_n   (key_clear_n),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_operation (alu_operation),
        .alu_sign      (alu_sign),
        .alu_result    (alu_result),
        .disp_value    (disp_value),
        .result_valid  (result_valid),
        .state_led     (state_led)
    );

    function automatic void model_clear();
        m_phase = P_OP1;
        m_op1 = 0; m_op2 = 0; m_oper = 0; m_sign = 0; m_res = 0; m_valid = 0;
    endfunction

    function automatic void model_enter(input logic [9:0] s);
        case (m_phase)
            P_OP1: begin m_op1 = s[3:0]; m_phase = P_OP2; end
            P_OP2: begin m_op2 = s[3:0]; m_phase = P_CMD; end
            P_CMD: begin
                m_oper = s[1]; m_sign = s[0];
                m_res  = m_oper ? RW'(int'(m_op1) * int'(m_op2)) : RW'(int'(m_op1) + int'(m_op2));
                m_valid = 1; m_phase = P_SHOW;
            end
            default: begin m_valid = 0; m_phase = P_OP1; end
        endcase
    endfunction

    function automatic logic [RW-1:0] exp_disp(input logic [9:0] s);
        case (m_phase)
            P_OP1, P_OP2: return RW'(s[3:0]);
            P_CMD:        return RW'(s[1:0]);
            default:      return m_res;
        endcase
    endfunction

    function automatic logic [2:0] exp_led();
        case (m_phase)
            P_OP1:   return 3'b001;
            P_OP2:   return 3'b010;
            P_CMD:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Press and release keys long enough for the debouncers to accept both edges.
    task automatic press(input bit do_enter, input bit do_clear);
        @(negedge clk);
        key_enter_n = ~do_enter;
        key_clear_n = ~do_clear;
        repeat (HOLD) @(negedge clk);
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        repeat (HOLD) @(negedge clk);
        if (do_clear) model_clear();
        else if (do_enter) model_enter(sw);
    endtask

    task automatic test_reset();
        sw = 10'h005;
        #1;
        n_checks++; if (state_led !== 3'b001) $display("FAIL reset_led: got %b expected 001", state_led); else n_pass++;
        n_checks++; if (result_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", result_valid); else n_pass++;
        n_checks++; if ({alu_op1, alu_op2, alu_operation, alu_sign} !== 10'd0)
            $display("FAIL reset_alu_regs: got %h expected 0", {alu_op1, alu_op2, alu_operation, alu_sign}); else n_pass++;
        n_checks++; if (disp_value !== RW'(5)) $display("FAIL reset_disp: got %0d expected 5", disp_value); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (state_led !== 3'b001) $display("FAIL post_reset_led: got %b expected 001", state_led); else n_pass++;
    endtask

    task automatic test_full_flow();
        press(0, 1);
        sw = 10'd3; press(1, 0);
        sw = 10'd5; press(1, 0);
        sw = 10'd0; press(1, 0);
        n_checks++; if (disp_value !== RW'(8)) $display("FAIL flow_disp: got %0d expected 8", disp_value); else n_pass++;
        n_checks++; if (result_valid !== 1'b1) $display("FAIL flow_valid: got %b expected 1", result_valid); else n_pass++;
        sw = 10'b10;
        repeat (5) @(negedge clk);
        n_checks++; if (disp_value !== RW'(8)) $display("FAIL flow_disp_hold: got %0d expected 8", disp_value); else n_pass++;
        n_checks++; if (alu_operation !== 1'b0) $display("FAIL flow_oper_hold: got %b expected 0", alu_operation); else n_pass++;
        $display("flow: 3+5 -> disp=%0d valid=%b", disp_value, result_valid);
    endtask

    task automatic test_bounce();
        press(0, 1);
        sw = 10'd9;
        @(negedge clk);
        key_enter_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i % 2 == 1) key_enter_n = ~key_enter_n;
        end
        n_checks++; if (state_led !== 3'b001) $display("FAIL bounce_no_early: got %b expected 001", state_led); else n_pass++;
        key_enter_n = 1'b0;
        repeat (HOLD) @(negedge clk);
        key_enter_n = 1'b1;
        repeat (HOLD) @(negedge clk);
        model_enter(sw);
        n_checks++; if (state_led !== 3'b010) $display("FAIL bounce_one_advance: got %b expected 010", state_led); else n_pass++;
        n_checks++; if (alu_op1 !== 4'd9) $display("FAIL bounce_op1: got %0d expected 9", alu_op1); else n_pass++;
        $display("bounce: led=%b op1=%0d", state_led, alu_op1);
    endtask

    task automatic test_held_key();
        press(0, 1);
        sw = 10'd11;
        @(negedge clk);
        key_enter_n = 1'b0;
        repeat (100) @(negedge clk);
        n_checks++; if (state_led !== 3'b010) $display("FAIL held_single_advance: got %b expected 010", state_led); else n_pass++;
        key_enter_n = 1'b1;
        repeat (HOLD) @(negedge clk);
        model_enter(sw);
        n_checks++; if (state_led !== 3'b010) $display("FAIL held_after_release: got %b expected 010", state_led); else n_pass++;
        n_checks++; if (alu_op1 !== 4'd11) $display("FAIL held_op1: got %0d expected 11", alu_op1); else n_pass++;
        $display("held: led=%b op1=%0d", state_led, alu_op1);
    endtask

    task automatic test_clear_priority();
        press(0, 1);
        sw = 10'd4; press(1, 0);
        sw = 10'd6; press(1, 0);
        n_checks++; if (state_led !== 3'b100) $display("FAIL clr_setup_cmd: got %b expected 100", state_led); else n_pass++;
        press(1, 1);
        n_checks++; if (state_led !== 3'b001) $display("FAIL clr_prio_led: got %b expected 001", state_led); else n_pass++;
        n_checks++; if ({alu_op1, alu_op2} !== 8'd0) $display("FAIL clr_prio_ops: got %h expected 0", {alu_op1, alu_op2}); else n_pass++;
        $display("clear_priority: led=%b op1=%0d op2=%0d", state_led, alu_op1, alu_op2);
    endtask

    task automatic test_latency();
        int t_exec, t_valid;
        press(0, 1);
        sw = 10'd7; press(1, 0);
        sw = 10'd6; press(1, 0);
        sw = 10'b10;
        t_exec = -1; t_valid = -1;
        @(negedge clk);
        key_enter_n = 1'b0;
        for (int c = 0; c < 60 && t_valid < 0; c++) begin
            @(negedge clk);
            if (t_exec < 0 && state_led == 3'b000) t_exec = c;
            if (t_exec >= 0 && result_valid === 1'b1) t_valid = c;
        end
        n_checks++;
        if (t_exec < 0 || t_valid < 0) $display("FAIL lat_timeout: exec=%0d valid=%0d expected both seen", t_exec, t_valid);
        else if (t_valid - t_exec != LAT) $display("FAIL lat_cycles: got %0d expected %0d", t_valid - t_exec, LAT);
        else n_pass++;
        n_checks++; if (disp_value !== RW'(42)) $display("FAIL lat_result: got %0d expected 42", disp_value); else n_pass++;
        repeat (20) @(negedge clk);
        n_checks++; if (result_valid !== 1'b1 || state_led !== 3'b000)
            $display("FAIL lat_enter_held: got valid=%b led=%b expected valid=1 led=000", result_valid, state_led); else n_pass++;
        key_enter_n = 1'b1;
        repeat (HOLD) @(negedge clk);
        model_enter(sw);
        press(1, 0);
        n_checks++; if (state_led !== 3'b001 || result_valid !== 1'b0)
            $display("FAIL lat_show_exit: got led=%b valid=%b expected led=001 valid=0", state_led, result_valid); else n_pass++;
        n_checks++; if (alu_op1 !== 4'd7 || alu_op2 !== 4'd6)
            $display("FAIL lat_regs_kept: got op1=%0d op2=%0d expected 7 6", alu_op1, alu_op2); else n_pass++;
        $display("latency: exec@%0d valid@%0d result=42 checked", t_exec, t_valid);
    endtask

    task automatic test_mid_exec_reset();
        bit found;
        press(0, 1);
        sw = 10'd1; press(1, 0);
        sw = 10'd2; press(1, 0);
        sw = 10'd3;
        found = 0;
        @(negedge clk);
        key_enter_n = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (state_led == 3'b000) found = 1;
        end
        n_checks++; if (!found) $display("FAIL mid_reset_exec_timeout: got no EXEC entry expected within 40 cycles"); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({alu_op1, alu_op2, alu_operation, alu_sign} !== 10'd0 || result_valid !== 1'b0)
            $display("FAIL mid_reset_regs: got %h valid=%b expected 0", {alu_op1, alu_op2, alu_operation, alu_sign}, result_valid); else n_pass++;
        n_checks++; if (state_led !== 3'b001 || disp_value !== RW'(3))
            $display("FAIL mid_reset_led_disp: got led=%b disp=%0d expected 001 3", state_led, disp_value); else n_pass++;
        key_enter_n = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        repeat (20) @(negedge clk);
        n_checks++; if (result_valid !== 1'b0 || state_led !== 3'b001)
            $display("FAIL mid_reset_no_partial: got valid=%b led=%b expected 0 001", result_valid, state_led); else n_pass++;
        $display("mid_exec_reset: led=%b valid=%b", state_led, result_valid);
    endtask

    task automatic test_random();
        press(0, 1);
        for (int t = 0; t < 40; t++) begin
            int r;
            sw = 10'($urandom);
            r = $urandom_range(0, 9);
            if (r == 0) press(0, 1); else press(1, 0);
            sw = 10'($urandom);
            #1;
            n_checks++; if (alu_op1 !== m_op1) $display("FAIL rnd_op1: got %0d expected %0d", alu_op1, m_op1); else n_pass++;
            n_checks++; if (alu_op2 !== m_op2) $display("FAIL rnd_op2: got %0d expected %0d", alu_op2, m_op2); else n_pass++;
            n_checks++; if ({alu_operation, alu_sign} !== {m_oper, m_sign})
                $display("FAIL rnd_cmd: got %b expected %b", {alu_operation, alu_sign}, {m_oper, m_sign}); else n_pass++;
            n_checks++; if (result_valid !== m_valid) $display("FAIL rnd_valid: got %b expected %b", result_valid, m_valid); else n_pass++;
            n_checks++; if (state_led !== exp_led()) $display("FAIL rnd_led: got %b expected %b", state_led, exp_led()); else n_pass++;
            n_checks++; if (disp_value !== exp_disp(sw)) $display("FAIL rnd_disp: got %0d expected %0d", disp_value, exp_disp(sw)); else n_pass++;
            $display("rnd %0d: %s phase=%0d disp=%0d valid=%b", t, (r == 0) ? "clear" : "enter", m_phase, disp_value, result_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sw = '0;
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        test_reset();
        test_full_flow();
        test_bounce();
        test_held_key();
        test_clear_priority();
        test_latency();
        test_mid_exec_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
